seq_chunk_comparator: RTL
=========================

Name: seq_chunk_comparator

Overview:
- Parametrised sequential magnitude comparator for N-bit operands. Successor to the fixed-width combinational comparator.
- Compares operands CHUNK bits per clock, MSB chunk first, and exits early at the first unequal chunk.
- Uses a start/busy/done handshake, so wide compares in datapath control logic need only a CHUNK-bit comparator.
- Result encoding matches the existing comparator family: R[2]=A>B, R[1]=A==B, R[0]=A<B.

Parameters:
- N, 16, operand width in bits. Must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits compared per clock, 1..N.
- NCH (localparam), N/CHUNK, number of chunks.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled on a rising clk edge.
- A  input  N  operand A; sampled only on an accepted start.
- B  input  N  operand B; sampled only on an accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when R is updated.
- R  output  3  one-hot result {gt,eq,lt}; holds its value until the next done.

Behaviour:
- Reset: clk is single; rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, busy=0, done=0, R=3'b000, internal operand and index registers cleared. Reset mid-compare aborts immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 on an edge:
  - latch A and B into shadow registers; idx=0; state=RUN; busy=1; done=0.
  - R keeps its previous value.
- IDLE or DONE, start=0: hold state. done=0 on every edge that is not a completion edge, so done is high for exactly one cycle.
- RUN, each edge: compare chunk idx, i.e. bits [N-1-idx*CHUNK -: CHUNK] of the shadow A and B.
  - Chunks unequal: R=100 or 001 per that chunk; state=DONE; busy=0; done=1.
  - Chunks equal and idx==NCH-1: R=010; state=DONE; busy=0; done=1.
  - Chunks equal otherwise: idx=idx+1; stay in RUN.
- start while in RUN is ignored and does not restart; A/B changes during RUN have no effect.
- Latency: k edges after the start edge, where k = 1-based index of the first differing chunk, or NCH if the operands are equal. Best case 1, worst case NCH.
- Back-to-back: start may be asserted on the same edge that leaves DONE, or held high continuously. The next compare is accepted on the edge after the done edge.
- Default comparison is unsigned. idx register width is clog2(NCH), minimum 1.
- CHUNK==N degenerates to a 1-cycle registered compare.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_CMP_SIGNED_EN.
- Defined:
  - adds input port signed_mode (1 bit), sampled with A/B on an accepted start.
  - when the latched signed_mode=1, the idx=0 chunk is compared with its MSB inverted on both operands (two's complement ordering). Remaining chunks are compared unsigned.
  - timing, handshake and latency are unchanged.
- Undefined: signed_mode port is absent; comparison is always unsigned.

Test Plan (N=16, CHUNK=4):
- Reset: assert rst_n=0 mid-cycle with no clock edge -> busy=0, done=0, R=000 immediately. Then start A=16'h1234, B=16'h1234 and pull rst_n low 2 edges in -> busy=0, no done pulse, R=000.
- Equal: A=16'h1234, B=16'h1234, start one cycle -> busy high 4 cycles; done pulses on the 4th edge after start; R=010.
- Early exit: A=16'h3000, B=16'hE000 -> done on the 1st edge after start, R=001. Then A=16'h12F4, B=16'h1294 -> done on the 3rd edge, R=100.
- Ignored start: start A=16'h0001, B=16'h0002. Re-assert start with A=16'hFFFF, B=16'h0000 on the 2nd RUN cycle -> only one done, after 4 edges, R=001, busy never re-raised. Hold start high continuously -> compares chain with exactly one idle edge between each done and the next busy.
- Signed (SEQ_CMP_SIGNED_EN): A=16'h8000, B=16'h0001, signed_mode=1 -> R=001 after 1 edge; same operands with signed_mode=0 -> R=100. A=16'hFFFF, B=16'hFFFE, signed_mode=1 -> R=100 after 4 edges.
- Sweep CHUNK=1 and CHUNK=16 (N=16) over randomised operands against a reference model -> R matches in all cases. Latency equals the first differing chunk index (CHUNK=1) or 1 edge (CHUNK=16).

Source files
------------

// File: rtl/seq_chunk_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_chunk_comparator                                       |
// | Description : Sequential N-bit magnitude comparator. Compares CHUNK bits |
// |               per clock, MSB chunk first, and exits at the first unequal |
// |               chunk. Result R = {gt, eq, lt}, one-hot, held until the    |
// |               next done pulse. Optional macro SEQ_CMP_SIGNED_EN adds a   |
// |               signed_mode input for two's complement ordering.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_chunk_comparator #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic         signed_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [2:0]   R
);

  localparam int NCH  = (CHUNK > 0) ? (N / CHUNK) : 1;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  // Reject widths that do not split into whole chunks.
  generate
    if ((CHUNK < 1) || (CHUNK > N) || ((N % ((CHUNK > 0) ? CHUNK : 1)) != 0)) begin : g_param_check
      $error("seq_chunk_comparator: N must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      r_q, r_d;
`ifdef SEQ_CMP_SIGNED_EN
  logic            signed_q, signed_d;
`endif

  logic [N-1:0]     a_sh, b_sh;
  logic [CHUNK-1:0] a_ch, b_ch;

  // Select the current chunk: shift it to the top, then take the top CHUNK bits.
  always_comb begin
    a_sh = a_q << (32'(idx_q) * CHUNK);
    b_sh = b_q << (32'(idx_q) * CHUNK);
    a_ch = a_sh[N-1 -: CHUNK];
    b_ch = b_sh[N-1 -: CHUNK];
`ifdef SEQ_CMP_SIGNED_EN
    // Flipping the sign bit of the leading chunk maps two's complement onto unsigned order.
    if (signed_q && (idx_q == '0)) begin
      a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
      b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
    end
`endif
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE handshake.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    r_d      = r_q;
`ifdef SEQ_CMP_SIGNED_EN
    signed_d = signed_q;
`endif
    case (state_q)
      S_RUN: begin
        if (a_ch > b_ch) begin
          r_d     = 3'b100;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (a_ch < b_ch) begin
          r_d     = 3'b001;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          r_d     = 3'b010;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        // IDLE and DONE behave identically: wait for start.
        if (start) begin
          a_d      = A;
          b_d      = B;
          idx_d    = '0;
          state_d  = S_RUN;
          busy_d   = 1'b1;
`ifdef SEQ_CMP_SIGNED_EN
          signed_d = signed_mode;
`endif
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= 3'b000;
`ifdef SEQ_CMP_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      r_q      <= r_d;
`ifdef SEQ_CMP_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;

endmodule
`default_nettype wire
